// File: rtl/dpr_port_arbiter.sv
// Front end for dual_port_ram: grants up to two requesters per cycle (one per RAM port)
// by round-robin, filters same-address write hazards, and routes read data back.
module dpr_port_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 6,
    parameter int unsigned DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rd_valid,
    output logic [NREQ*DW-1:0]   rd_data,
    output logic [DW-1:0]        data1,
    output logic [AW-1:0]        adr1,
    output logic                 en1,
    output logic [DW-1:0]        data2,
    output logic [AW-1:0]        adr2,
    output logic                 en2,
    input  logic [DW-1:0]        out1,
    input  logic [DW-1:0]        out2
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [AW-1:0] addr [NREQ];
    logic [DW-1:0] wdat [NREQ];
    logic [DW-1:0] rdq  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign addr[g]             = req_addr[g*AW +: AW];
        assign wdat[g]             = req_wdata[g*DW +: DW];
        assign rd_data[g*DW +: DW] = rdq[g];
    end

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [IW-1:0] a_idx;
    logic [IW-1:0] b_idx;
    logic [IW-1:0] last_idx;
    logic          a_vld;
    logic          b_vld;

    // Scan from ptr; B must not touch A's address unless both are reads.
    always_comb begin
        a_vld = 1'b0;
        b_vld = 1'b0;
        a_idx = '0;
        b_idx = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr + IW'(k);
            if (req[idx] && !rst) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = idx;
                end else if (!b_vld &&
                             !((addr[idx] == addr[a_idx]) && (req_we[idx] || req_we[a_idx]))) begin
                    b_vld = 1'b1;
                    b_idx = idx;
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (a_vld) gnt[a_idx] = 1'b1;
        if (b_vld) gnt[b_idx] = 1'b1;
        last_idx = b_vld ? b_idx : a_idx;
    end

    // Round-robin pointer moves past the last requester served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (a_vld) begin
            ptr <= last_idx + IW'(1);
        end
    end

    logic          p1_vld;
    logic          p2_vld;
    logic [IW-1:0] p1_id;
    logic [IW-1:0] p2_id;

    // RAM command registers; an idle port issues a harmless read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en1    <= 1'b0;
            adr1   <= '0;
            data1  <= '0;
            en2    <= 1'b0;
            adr2   <= '0;
            data2  <= '0;
            p1_vld <= 1'b0;
            p1_id  <= '0;
            p2_vld <= 1'b0;
            p2_id  <= '0;
        end else begin
            en1    <= a_vld && req_we[a_idx];
            en2    <= b_vld && req_we[b_idx];
            p1_vld <= a_vld && !req_we[a_idx];
            p1_id  <= a_idx;
            p2_vld <= b_vld && !req_we[b_idx];
            p2_id  <= b_idx;
            if (a_vld) begin
                adr1  <= addr[a_idx];
                data1 <= wdat[a_idx];
            end
            if (b_vld) begin
                adr2  <= addr[b_idx];
                data2 <= wdat[b_idx];
            end
        end
    end

    // Capture RAM read data for the requester that issued the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                rdq[i] <= '0;
            end
        end else begin
            rd_valid <= '0;
            if (p1_vld) begin
                rd_valid[p1_id] <= 1'b1;
                rdq[p1_id]      <= out1;
            end
            if (p2_vld) begin
                rd_valid[p2_id] <= 1'b1;
                rdq[p2_id]      <= out2;
            end
        end
    end

endmodule
